bram_access_arbiter: RTL

- Shares a single-port user BRAM between two requesters:
  - the Wishbone slave path from the management SoC, decoded at address tag 0x38;
  - a user-side accelerator request port.
- Owns the BRAM EN/WE/A/Di pins and inserts a fixed DELAYS-cycle access window per transaction.
- Returns read data with a one-cycle acknowledge to whichever requester won arbitration.
- Sits between the Wishbone interface / accelerator and the bram macro inside the user project.

---
 rtl/bram_access_arbiter.sv | 130 +++++++++++++
 1 files changed

// File: rtl/bram_access_arbiter.sv
// rtl/bram_access_arbiter.sv - shares one single-port BRAM between the Wishbone slave path and an accelerator port
module bram_access_arbiter #(
   parameter int unsigned DELAYS   = 10,
   parameter logic [7:0]  ADDR_TAG = 8'h38
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        wbs_cyc_i,
   input  logic        wbs_stb_i,
   input  logic        wbs_we_i,
   input  logic [3:0]  wbs_sel_i,
   input  logic [31:0] wbs_adr_i,
   input  logic [31:0] wbs_dat_i,
   output logic        wbs_ack_o,
   output logic [31:0] wbs_dat_o,
   input  logic        usr_req_i,
   input  logic [3:0]  usr_we_i,
   input  logic [31:0] usr_addr_i,
   input  logic [31:0] usr_wdata_i,
   output logic        usr_ack_o,
   output logic [31:0] usr_rdata_o,
   output logic        bram_en_o,
   output logic [3:0]  bram_we_o,
   output logic [31:0] bram_a_o,
   output logic [31:0] bram_di_o,
   input  logic [31:0] bram_do_i,
   output logic        busy_o
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic       OWN_WB   = 1'b0;
   localparam logic       OWN_USR  = 1'b1;
   localparam logic [3:0] CNT_LAST = 4'(DELAYS - 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  we_q, we_d;
   logic [31:0] rdata_q, rdata_d;

   logic wb_req;
   logic usr_req;
   logic grant_usr;

   assign wb_req  = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:24] == ADDR_TAG);
   assign usr_req = usr_req_i;

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      we_d         = we_q;
      rdata_d      = rdata_q;
      grant_usr    = 1'b0;

      case (state_q)
         IDLE: begin
            if (wb_req || usr_req) begin
               // On a tie the requester that was not served last wins
               if (wb_req && usr_req) grant_usr = (last_owner_q == OWN_WB);
               else                   grant_usr = usr_req;
               owner_d      = grant_usr ? OWN_USR : OWN_WB;
               last_owner_d = grant_usr ? OWN_USR : OWN_WB;
               addr_d       = grant_usr ? usr_addr_i  : wbs_adr_i;
               wdata_d      = grant_usr ? usr_wdata_i : wbs_dat_i;
               we_d         = grant_usr ? usr_we_i    : (wbs_sel_i & {4{wbs_we_i}});
               cnt_d        = 4'd0;
               state_d      = BUSY;
            end
         end
         BUSY: begin
            if (owner_q == OWN_WB && !wbs_cyc_i) begin
               cnt_d   = 4'd0;
               state_d = IDLE;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = bram_do_i;
               cnt_d   = 4'd0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_q      <= IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= OWN_WB;
         last_owner_q <= OWN_USR;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         we_q         <= 4'd0;
         rdata_q      <= 32'd0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         we_q         <= we_d;
         rdata_q      <= rdata_d;
      end
   end

   // Write strobes only on the first window cycle; the rest of the window is read settling time
   always_comb begin
      bram_en_o   = (state_q == BUSY);
      bram_we_o   = (state_q == BUSY && cnt_q == 4'd0) ? we_q : 4'd0;
      bram_a_o    = addr_q;
      bram_di_o   = wdata_q;
      busy_o      = (state_q != IDLE);
      wbs_ack_o   = (state_q == DONE) && (owner_q == OWN_WB);
      usr_ack_o   = (state_q == DONE) && (owner_q == OWN_USR);
      wbs_dat_o   = wbs_ack_o ? rdata_q : 32'd0;
      usr_rdata_o = usr_ack_o ? rdata_q : 32'd0;
   end

endmodule
